// File: rtl/log2_lut_interp_if.sv
// Handshake and ROM-port bundle of the log2 unit.
// Latency: none; this is wiring only.
// Backpressure: carries in_ready/out_ready between the unit and its neighbours.
interface log2_lut_interp_if #(
  parameter int IN_WIDTH   = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 20,
  parameter int E_WIDTH    = $clog2(IN_WIDTH)
);
  // operand side
  logic                          in_valid;
  logic                          in_ready;
  logic [IN_WIDTH-1:0]           in_data;
  // dual-port ROM side
  logic [ADDR_WIDTH-1:0]         lut_addr_a;
  logic [ADDR_WIDTH-1:0]         lut_addr_b;
  logic [DATA_WIDTH-1:0]         lut_q_a;
  logic [DATA_WIDTH-1:0]         lut_q_b;
  // result side
  logic                          out_valid;
  logic                          out_ready;
  logic [E_WIDTH+DATA_WIDTH-1:0] out_data;
  logic                          out_err;

  // the log2 unit itself
  modport slave (
    input  in_valid, in_data, lut_q_a, lut_q_b, out_ready,
    output in_ready, lut_addr_a, lut_addr_b, out_valid, out_data, out_err
  );

  // environment: operand producer, ROM and result consumer
  modport master (
    output in_valid, in_data, lut_q_a, lut_q_b, out_ready,
    input  in_ready, lut_addr_a, lut_addr_b, out_valid, out_data, out_err
  );
endinterface

// File: rtl/log2_lut_interp.sv
// Fixed-point log2: normalise, look up L[idx]/L[idx+1] in an external ROM, interpolate.
// Latency: operand presented in cycle T -> result valid after edge T+3; 1 result/cycle.
// Backpressure: single global advance enable; out stall freezes every stage and drops in_ready.
module log2_lut_interp #(
  parameter int IN_WIDTH   = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 20,
  parameter int R_BITS     = 8,
  parameter int E_WIDTH    = $clog2(IN_WIDTH)
) (
  input logic                clk,
  input logic                rst,
  log2_lut_interp_if.slave   bus
);

  // mantissa padded so idx and r can always be sliced from the top, even if
  // IN_WIDTH-1 is narrower than ADDR_WIDTH+R_BITS
  localparam int MW = IN_WIDTH - 1 + ADDR_WIDTH + R_BITS;
  localparam int PW = DATA_WIDTH + R_BITS + 1;
  localparam logic [DATA_WIDTH:0] ONE_HI = {1'b1, {DATA_WIDTH{1'b0}}};

  // global advance
  logic                          en;

  // S1 combinational normalisation
  logic [E_WIDTH-1:0]            lead_e;
  logic [E_WIDTH-1:0]            norm_sh;
  logic [IN_WIDTH-1:0]           norm_x;
  logic [MW-1:0]                 m_pad;
  logic [ADDR_WIDTH-1:0]         in_idx;
  logic [R_BITS-1:0]             in_r;
  logic                          in_z;

  // S1 registers
  logic                          s1_valid;
  logic [E_WIDTH-1:0]            s1_e;
  logic [ADDR_WIDTH-1:0]         s1_idx;
  logic [R_BITS-1:0]             s1_r;
  logic                          s1_z;

  // S2 registers
  logic                          s2_valid;
  logic [E_WIDTH-1:0]            s2_e;
  logic [R_BITS-1:0]             s2_r;
  logic                          s2_z;
  logic                          s2_wrap;

  // ROM data capture
  logic                          q_fresh;
  logic [DATA_WIDTH-1:0]         qa_sav;
  logic [DATA_WIDTH-1:0]         qb_sav;
  logic [DATA_WIDTH-1:0]         qa;
  logic [DATA_WIDTH-1:0]         qb;

  // interpolation
  logic [DATA_WIDTH:0]           hi;
  logic [DATA_WIDTH:0]           diff;
  logic [PW-1:0]                 prod;
  logic [DATA_WIDTH:0]           step;
  logic [DATA_WIDTH-1:0]         frac;
  logic [E_WIDTH+DATA_WIDTH-1:0] nxt_data;

  // output registers
  logic                          out_valid_q;
  logic [E_WIDTH+DATA_WIDTH-1:0] out_data_q;
  logic                          out_err_q;

  // bits that are dropped by construction (leading one, truncated products)
  logic                          unused_bits;

  assign en           = !out_valid_q || bus.out_ready;
  assign bus.in_ready = en;

  // priority encoder: highest set bit wins because later iterations overwrite
  always_comb begin
    lead_e = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (bus.in_data[i]) lead_e = E_WIDTH'(i);
    end
  end

  // shift the leading one up to the MSB; the bits below it form the mantissa.
  // x == 0 gives lead_e = 0 and an all-zero shift result, so idx = r = 0.
  assign norm_sh = E_WIDTH'(IN_WIDTH - 1) - lead_e;
  assign norm_x  = bus.in_data << norm_sh;
  assign m_pad   = {norm_x[IN_WIDTH-2:0], {(ADDR_WIDTH + R_BITS){1'b0}}};
  assign in_idx  = m_pad[MW-1 -: ADDR_WIDTH];
  assign in_r    = m_pad[MW-1-ADDR_WIDTH -: R_BITS];
  assign in_z    = (bus.in_data == '0);

  // S1: capture the normalised operand on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_e     <= '0;
      s1_idx   <= '0;
      s1_r     <= '0;
      s1_z     <= 1'b0;
    end else if (en) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_e   <= lead_e;
        s1_idx <= in_idx;
        s1_r   <= in_r;
        s1_z   <= in_z;
      end
    end
  end

  // ROM addresses come straight from S1 so the ROM reads S1's item on the
  // same edge that moves it into S2
  assign bus.lut_addr_a = s1_idx;
  assign bus.lut_addr_b = s1_idx + ADDR_WIDTH'(1);

  // S2: exponent, weight and wrap flag wait here for the ROM words
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_e     <= '0;
      s2_r     <= '0;
      s2_z     <= 1'b0;
      s2_wrap  <= 1'b0;
    end else if (en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_e    <= s1_e;
        s2_r    <= s1_r;
        s2_z    <= s1_z;
        s2_wrap <= (s1_idx == '1);
      end
    end
  end

  // ROM words belong to S2 only in the first cycle after S2 loads; keep a
  // copy so a stall does not let S1's lookup overwrite them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_fresh <= 1'b0;
      qa_sav  <= '0;
      qb_sav  <= '0;
    end else begin
      q_fresh <= en && s1_valid;
      if (q_fresh) begin
        qa_sav <= bus.lut_q_a;
        qb_sav <= bus.lut_q_b;
      end
    end
  end

  assign qa = q_fresh ? bus.lut_q_a : qa_sav;
  assign qb = q_fresh ? bus.lut_q_b : qb_sav;

  // linear interpolation; the last segment's upper end is 1.0, which does not
  // fit in a ROM word, hence the wrap substitution
  always_comb begin
    hi       = s2_wrap ? ONE_HI : {1'b0, qb};
    diff     = hi - {1'b0, qa};
    prod     = {{R_BITS{1'b0}}, diff} * {{(DATA_WIDTH + 1){1'b0}}, s2_r};
    step     = prod[PW-1 -: (DATA_WIDTH + 1)];
    frac     = qa + step[DATA_WIDTH-1:0];
    nxt_data = s2_z ? '0 : {s2_e, frac};
  end

  assign unused_bits = ^{norm_x[IN_WIDTH-1], prod[R_BITS-1:0], step[DATA_WIDTH]};

  // OUT: result register, held stable while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
    end else if (en) begin
      out_valid_q <= s2_valid;
      if (s2_valid) begin
        out_data_q <= nxt_data;
        out_err_q  <= s2_z;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_log2_lut_interp.sv
module tb_log2_lut_interp;
  localparam int IN_W = 16;
  localparam int AW   = 4;
  localparam int DW   = 20;
  localparam int RB   = 8;
  localparam int EW   = 4;

  typedef struct {
    logic [24:0] exp;
    int          cyc;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  log2_lut_interp_if #(.IN_WIDTH(IN_W), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .E_WIDTH(EW)) bus ();

  log2_lut_interp #(.IN_WIDTH(IN_W), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .R_BITS(RB), .E_WIDTH(EW))
    dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_stall = -10;
  bit prev_stall = 1'b0;
  logic [23:0] prev_data;
  item_t exp_q[$];
  logic [24:0] emit_log[$];
  logic [DW-1:0] rom [16];

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // reference: L[i] = floor(log2(1 + i/16) * 2^20)
  initial begin
    for (int i = 0; i < 16; i++) begin
      real v;
      v = $ln(1.0 + real'(i) / 16.0) / $ln(2.0) * 1048576.0;
      rom[i] = DW'($rtoi($floor(v)));
    end
  end

  // dual-port ROM with registered read
  always_ff @(posedge clk) begin
    bus.lut_q_a <= rom[bus.lut_addr_a];
    bus.lut_q_b <= rom[bus.lut_addr_b];
  end

  // behavioural model: returns {err, data}
  function automatic logic [24:0] model(input longint x);
    longint e, mm, idx, r, lo, hi, frac;
    if (x == 0) return 25'h1000000;
    e = 0;
    for (int i = 0; i < 16; i++) if (x >= (longint'(1) << i)) e = i;
    mm   = (x - (longint'(1) << e)) * (longint'(1) << (15 - e));
    idx  = mm / 2048;
    r    = (mm / 8) % 256;
    lo   = rom[idx];
    hi   = (idx == 15) ? 1048576 : rom[idx + 1];
    frac = lo + ((hi - lo) * r) / 256;
    return {1'b0, 4'(e), 20'(frac)};
  endfunction

  // scoreboard: every cycle, away from the active edge
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      check("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
      if (prev_stall) begin
        check("stall_valid_held", bus.out_valid, 1);
        check("stall_data_held", bus.out_data, prev_data);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          item_t it;
          it = exp_q.pop_front();
          check("out_result", {bus.out_err, bus.out_data}, it.exp);
          if (last_stall < it.cyc) check("latency", cyc - it.cyc, 3);
          emit_log.push_back({bus.out_err, bus.out_data});
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        item_t ni;
        ni.exp = model(bus.in_data);
        ni.cyc = cyc;
        exp_q.push_back(ni);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      if (prev_stall) last_stall = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] x);
    int g;
    bit acc;
    g = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    do begin
      acc = bus.in_ready;
      tick();
      g++;
    end while (!acc && g < 50);
    bus.in_valid = 1'b0;
    check("send_accept", acc, 1);
  endtask

  task automatic wait_emits(input int n);
    int g;
    g = 0;
    while (emit_log.size() < n && g < 40) begin
      tick();
      g++;
    end
    check("emit_count", emit_log.size(), n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [24:0] e3;
    logic [15:0] rx;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // reset state
    repeat (2) tick();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_err", bus.out_err, 0);
    check("rst_addr_a", bus.lut_addr_a, 0);
    check("rst_addr_b", bus.lut_addr_b, 1);
    rst = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 1);

    // hand-computed pins of the reference table and model
    check("pin_L0", rom[0], 0);
    check("pin_L8", rom[8], 613377);
    check("pin_model_x1", model(1), 25'h0000000);
    check("pin_model_x8000", model(16'h8000), 25'h0F00000);
    check("pin_model_x0", model(0), 25'h1000000);

    // powers of two, back to back
    emit_log.delete();
    send(16'd1);
    send(16'd2);
    send(16'h8000);
    wait_emits(3);
    check("pow2_x1", emit_log[0], 25'h0000000);
    check("pow2_x2", emit_log[1], 25'h0100000);
    check("pow2_x8000", emit_log[2], 25'h0F00000);

    // x = 24: ROM addresses and r = 0 result
    emit_log.delete();
    send(16'd24);
    check("x24_addr_a", bus.lut_addr_a, 8);
    check("x24_addr_b", bus.lut_addr_b, 9);
    wait_emits(1);
    check("x24_out", emit_log[0], 25'h0400000 | 25'(rom[8]));

    // x = 0xFFFF: wrap segment, no carry into the exponent
    emit_log.delete();
    send(16'hFFFF);
    check("xffff_addr_a", bus.lut_addr_a, 15);
    check("xffff_addr_b", bus.lut_addr_b, 0);
    wait_emits(1);
    check("xffff_out", emit_log[0],
          25'h0F00000 | 25'(rom[15] + (((32'h100000 - 32'(rom[15])) * 255) >> 8)));
    check("xffff_exp_field", emit_log[0][23:20], 15);

    // zero operand then a normal one
    emit_log.delete();
    send(16'd0);
    send(16'd3);
    wait_emits(2);
    check("x0_err_data", emit_log[0], 25'h1000000);
    check("x3_after_zero", emit_log[1], 25'h0100000 | 25'(rom[8]));

    // fill the pipe under a stalled consumer, then release
    emit_log.delete();
    bus.out_ready = 1'b0;
    send(16'd3);
    send(16'd5);
    send(16'd7);
    for (int i = 0; i < 5; i++) begin
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_out_valid", bus.out_valid, 1);
      tick();
    end
    bus.out_ready = 1'b1;
    wait_emits(3);
    e3 = 25'h0100000 | 25'(rom[8]);
    check("stall_x3", emit_log[0], e3);
    check("stall_x5", emit_log[1], model(5));
    check("stall_x7", emit_log[2], model(7));

    // reset with items in flight
    emit_log.delete();
    send(16'd100);
    send(16'd200);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_addr_a", bus.lut_addr_a, 0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    check("midrst_no_stale", emit_log.size(), 0);
    send(16'd2);
    wait_emits(1);
    check("midrst_x2", emit_log[0], 25'h0100000);

    // randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      case ($urandom % 4)
        0:       rx = 16'd0;
        1:       rx = 16'($urandom % 16);
        2:       rx = 16'hFFFF - 16'($urandom % 8);
        default: rx = 16'($urandom);
      endcase
      bus.in_valid  = ($urandom % 3) != 0;
      bus.in_data   = rx;
      bus.out_ready = ($urandom % 4) != 0;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) tick();
    check("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
